// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
// Purpose: SPI mode-0 target with oversampled sclk/mosi/cs_n. It has a one-byte TX holding register and an RX byte register with acknowledge.
// Latency: pin-to-action is SYNC_STAGES+1 raw_clk cycles. rx_valid rises on the cycle the 8th sclk rising edge is acted on.
// Backpressure: no stall. tx_load is ignored while tx_ready=0. An unacknowledged rx byte is overwritten and sets the sticky overrun flag.
//
// Ports:
//   raw_clk, reset_n      : only clock; asynchronous active-low reset
//   cs_n, sclk, mosi      : asynchronous SPI pins from the initiator
//   miso                  : serial data out (0 while deselected)
//   tx_data/tx_load       : byte offered to the holding register
//   tx_ready              : holding register empty
//   rx_data/rx_valid      : last complete byte and its pending flag
//   rx_ack                : clears rx_valid and overrun
//   busy                  : frame in progress (synchronised cs_n low)
//   overrun               : byte completed while rx_valid was still set
// Build option: define SPI_PERIPHERAL_LSB_FIRST_EN for LSB-first in both directions.
// The default build is MSB-first.

module spi_peripheral #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'h00
) (
    input  logic       raw_clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {ST_IDLE, ST_SELECTED} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_hist, sclk_hist;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, cs_rise, sclk_fall, sclk_rise;

    logic [7:0] tx_hold, tx_shift, rx_shift;
    logic [2:0] bit_cnt;

    logic       load_evt, shift_evt, rise_evt, byte_done, consume, tx_accept;
    logic [7:0] load_src, tx_shifted, rx_next;
    logic       load_bit, shift_bit;

    // The cs_n chain resets to 0 (not 1). If cs_n is already low when reset is
    // released, no falling edge is seen, so a new frame needs a real high->low
    // toggle. If cs_n is high, the 0->1 transition seen after release is a
    // harmless rising edge while already IDLE.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_hist   <= 1'b0;
            sclk_hist <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_hist & ~cs_s;
    assign cs_rise   = ~cs_hist & cs_s;
    assign sclk_rise = ~sclk_hist & sclk_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    assign load_src = tx_ready ? IDLE_FILL : tx_hold;

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    assign load_bit   = load_src[0];
    assign tx_shifted = {1'b0, tx_shift[7:1]};
    assign shift_bit  = tx_shift[1];
    assign rx_next    = {mosi_s, rx_shift[7:1]};
`else
    assign load_bit   = load_src[7];
    assign tx_shifted = {tx_shift[6:0], 1'b0};
    assign shift_bit  = tx_shift[6];
    assign rx_next    = {rx_shift[6:0], mosi_s};
`endif

    // State register
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-cycle events. A cs_n rise overrides any sclk activity
    // seen in the same cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load_evt  = 1'b0;
        shift_evt = 1'b0;
        rise_evt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_SELECTED;
                    load_evt  = 1'b1;
                end
            end
            ST_SELECTED: begin
                busy = 1'b1;
                if (cs_rise) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rise_evt = sclk_rise;
                    // Falling edge at a byte boundary refills from the holding register.
                    load_evt  = sclk_fall && (bit_cnt == 3'd0);
                    shift_evt = sclk_fall && (bit_cnt != 3'd0);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign byte_done = rise_evt && (bit_cnt == 3'd7);
    assign consume   = load_evt && !tx_ready;
    // A load coinciding with the holding register draining is accepted.
    assign tx_accept = tx_load && (tx_ready || consume);

    // Shift path and miso
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            miso     <= 1'b0;
        end else if (cs_rise) begin
            bit_cnt <= '0;
            miso    <= 1'b0;
        end else if (load_evt) begin
            tx_shift <= load_src;
            miso     <= load_bit;
            if (state == ST_IDLE) bit_cnt <= '0;
        end else if (shift_evt) begin
            tx_shift <= tx_shifted;
            miso     <= shift_bit;
        end else if (rise_evt) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // TX holding register
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold  <= '0;
            tx_ready <= 1'b1;
        end else if (tx_accept) begin
            tx_hold  <= tx_data;
            tx_ready <= 1'b0;
        end else if (consume) begin
            tx_ready <= 1'b1;
        end
    end

    // RX byte register. A completing byte takes priority over rx_ack.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (byte_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ack) overrun <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for spi_peripheral. The SPI initiator is modelled in tasks.
// Latency: one sclk phase is PH raw_clk cycles. cs_n lead and lag are 8 cycles.
// Backpressure: none. The bench drives all inputs on the falling raw_clk edge and samples there too.

module tb_spi_peripheral;

    localparam int PH = 6;

    logic       raw_clk = 1'b0;
    logic       reset_n;
    logic       cs_n, sclk, mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] mi, mi2;

    spi_peripheral #(.SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
        .raw_clk  (raw_clk),
        .reset_n  (reset_n),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(1);
    endtask

    // Mode-0 initiator: mosi changes while sclk is low, and miso is sampled at
    // each sclk falling instant. With ack_last set, rx_ack is raised so that it
    // coincides with the cycle the DUT acts on the 8th rising edge
    // (SYNC_STAGES+1 = 3 cycles after sclk rises).
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit ack_last,
                        output logic [7:0] mi_o);
        mi_o = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            cyc(PH);
            sclk = 1'b1;
            if (ack_last && i == 7) begin
                cyc(2);
                rx_ack = 1'b1;
                cyc(1);
                rx_ack = 1'b0;
                cyc(PH-3);
            end else begin
                cyc(PH);
            end
            sclk = 1'b0;
            mi_o[7-i] = miso;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic frame_end();
        cyc(PH);
        cs_n = 1'b1;
        cyc(8);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_miso"},     {7'd0, miso},     8'h00);
        chk({pfx, "_tx_ready"}, {7'd0, tx_ready}, 8'h01);
        chk({pfx, "_rx_data"},  rx_data,          8'h00);
        chk({pfx, "_rx_valid"}, {7'd0, rx_valid}, 8'h00);
        chk({pfx, "_busy"},     {7'd0, busy},     8'h00);
        chk({pfx, "_overrun"},  {7'd0, overrun},  8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        rx_ack  = 1'b0;

        // Reset state, during reset and after release
        cyc(3);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        cyc(6);
        chk_reset_vals("post_rst");

        // A5 out, 3C in
        load_tx(8'hA5);
        chk("t2_tx_ready_loaded", {7'd0, tx_ready}, 8'h00);
        frame_start();
        chk("t2_tx_ready_cs", {7'd0, tx_ready}, 8'h01);
        chk("t2_busy", {7'd0, busy}, 8'h01);
        xfer(8'h3C, 8, 1'b0, mi);
        frame_end();
        chk("t2_miso_byte", mi, 8'hA5);
        chk("t2_rx_data", rx_data, 8'h3C);
        chk("t2_rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("t2_overrun", {7'd0, overrun}, 8'h00);
        chk("t2_busy_end", {7'd0, busy}, 8'h00);
        pulse_ack();
        chk("t2_ack_valid", {7'd0, rx_valid}, 8'h00);

        // Two bytes, no ack, tx empty: overrun
        frame_start();
        xfer(8'h11, 8, 1'b0, mi);
        xfer(8'h22, 8, 1'b0, mi2);
        frame_end();
        chk("t3_miso_b1", mi, 8'h00);
        chk("t3_miso_b2", mi2, 8'h00);
        chk("t3_rx_data", rx_data, 8'h22);
        chk("t3_rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("t3_overrun", {7'd0, overrun}, 8'h01);
        pulse_ack();
        chk("t3_ack_valid", {7'd0, rx_valid}, 8'h00);
        chk("t3_ack_overrun", {7'd0, overrun}, 8'h00);

        // Aborted partial byte, then F0
        frame_start();
        xfer(8'hAA, 4, 1'b0, mi);
        frame_end();
        chk("t4_abort_valid", {7'd0, rx_valid}, 8'h00);
        chk("t4_abort_data", rx_data, 8'h22);
        frame_start();
        xfer(8'hF0, 8, 1'b0, mi);
        frame_end();
        chk("t4_rx_data", rx_data, 8'hF0);
        chk("t4_rx_valid", {7'd0, rx_valid}, 8'h01);
        pulse_ack();

        // Ignored load while full; ack coinciding with byte 2 completion
        load_tx(8'h5A);
        load_tx(8'h99);
        chk("t5_tx_ready_full", {7'd0, tx_ready}, 8'h00);
        frame_start();
        xfer(8'h77, 8, 1'b0, mi);
        xfer(8'h88, 8, 1'b1, mi2);
        frame_end();
        chk("t5_miso_b1", mi, 8'h5A);
        chk("t5_miso_b2", mi2, 8'h00);
        chk("t5_rx_data", rx_data, 8'h88);
        chk("t5_rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("t5_overrun", {7'd0, overrun}, 8'h00);

        // Reset mid-byte with cs_n held low
        frame_start();
        xfer(8'hFF, 3, 1'b0, mi);
        load_tx(8'hC3);
        chk("t6_tx_ready_pre", {7'd0, tx_ready}, 8'h00);
        chk("t6_busy_pre", {7'd0, busy}, 8'h01);
        reset_n = 1'b0;
        cyc(2);
        chk_reset_vals("t6_rst");
        reset_n = 1'b1;
        cyc(10);
        chk("t6_busy_after", {7'd0, busy}, 8'h00);
        xfer(8'h5A, 8, 1'b0, mi);
        cyc(8);
        chk("t6_noxfer_valid", {7'd0, rx_valid}, 8'h00);
        chk("t6_noxfer_data", rx_data, 8'h00);
        chk("t6_noxfer_miso", mi, 8'h00);
        cs_n = 1'b1;
        cyc(8);
        frame_start();
        chk("t6_busy_new", {7'd0, busy}, 8'h01);
        xfer(8'h96, 8, 1'b0, mi);
        frame_end();
        chk("t6_rx_data", rx_data, 8'h96);
        chk("t6_rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("t6_miso_byte", mi, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
